issue_queue: RTL

Parametrised in-order instruction queue with multi-issue hazard screening. It sits between decode and the issue/register-read stage. Each cycle it accepts a fetch group of up to FETCH_WIDTH decoded instructions and compacts the valid ones into a circular buffer. It then issues the longest hazard-free in-order prefix of up to ISSUE_WIDTH oldest entries as calculation_type lanes, and back-pressures decode by a registered stall.

---
 rtl/issue_queue_pkg.sv | 140 ++++++++++++++
 rtl/issue_queue_if.sv | 24 ++
 rtl/issue_queue_ctrl.sv | 122 ++++++++++++
 rtl/issue_queue_ram.sv | 28 ++
 rtl/issue_queue.sv | 40 ++++
 5 files changed

// File: rtl/issue_queue_pkg.sv
// Shared types for the in-order issue queue: queue geometry, instruction and
// calculation bundles, RAM and controller port structs, hazard screening helpers.
package issue_queue_wires;

    localparam int FETCH_WIDTH = 2;
    localparam int ISSUE_WIDTH = 4;
    localparam int DEPTH       = 16;
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int CNT_W       = $clog2(DEPTH) + 1;
    localparam int ICNT_W      = $clog2(ISSUE_WIDTH) + 1;

    localparam logic [11:0] csr_fflags = 12'h001;
    localparam logic [11:0] csr_fcsr   = 12'h003;

    typedef struct packed {
        logic valid;
        logic wren;
        logic rden1;
        logic rden2;
        logic fwren;
        logic frden1;
        logic frden2;
        logic frden3;
        logic fpunit;
        logic division;
        logic mult;
        logic bitc;
        logic csreg;
        logic load;
        logic store;
        logic fload;
        logic fstore;
        logic fpuf;
        logic fence;
        logic mret;
        logic wfi;
    } operation_type;

    typedef struct packed {
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic [31:0]   imm;
        logic [11:0]   caddr;
        logic [4:0]    waddr;
        logic [4:0]    raddr1;
        logic [4:0]    raddr2;
        logic [4:0]    raddr3;
        operation_type op;
    } instruction_type;

    typedef struct packed {
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic [31:0]   imm;
        logic [11:0]   caddr;
        logic [4:0]    waddr;
        logic [4:0]    raddr1;
        logic [4:0]    raddr2;
        logic [4:0]    raddr3;
        operation_type op;
    } calculation_type;

    localparam calculation_type init_calculation = '0;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0]            wren;
        logic [FETCH_WIDTH-1:0][PTR_W-1:0] waddr;
        instruction_type [FETCH_WIDTH-1:0] wdata;
        logic [ISSUE_WIDTH-1:0][PTR_W-1:0] raddr;
    } issue_queue_ram_in_type;

    typedef struct packed {
        instruction_type [ISSUE_WIDTH-1:0] rdata;
    } issue_queue_ram_out_type;

    typedef struct packed {
        logic                              clear;
        logic                              stall_in;
        instruction_type [FETCH_WIDTH-1:0] enq_instr;
    } issue_queue_in_type;

    typedef struct packed {
        calculation_type [ISSUE_WIDTH-1:0] issue_calc;
        logic [ICNT_W-1:0]                 issue_count;
        logic                              stall_out;
        logic [CNT_W-1:0]                  count;
    } issue_queue_out_type;

    typedef struct packed {
        logic [PTR_W-1:0] wptr;
        logic [PTR_W-1:0] rptr;
        logic [CNT_W-1:0] count;
        logic             stall;
    } issue_queue_reg_type;

    localparam issue_queue_reg_type init_reg = '0;

    function automatic calculation_type to_calc(instruction_type x);
        calculation_type c;
        c        = init_calculation;
        c.pc     = x.pc;
        c.instr  = x.instr;
        c.imm    = x.imm;
        c.caddr  = x.caddr;
        c.waddr  = x.waddr;
        c.raddr1 = x.raddr1;
        c.raddr2 = x.raddr2;
        c.raddr3 = x.raddr3;
        c.op     = x.op;
        return c;
    endfunction

    function automatic logic is_serial(instruction_type x);
        return x.op.fence | x.op.mret | x.op.wfi;
    endfunction

    // True when younger i may not issue in the same group as older j
    function automatic logic is_hazard(instruction_type j, instruction_type i);
        logic h;
        h = 1'b0;
        if (j.op.wren && ((i.op.rden1 && i.raddr1 == j.waddr) ||
                          (i.op.rden2 && i.raddr2 == j.waddr)))
            h = 1'b1;
        if (j.op.fwren && ((i.op.frden1 && i.raddr1 == j.waddr) ||
                           (i.op.frden2 && i.raddr2 == j.waddr) ||
                           (i.op.frden3 && i.raddr3 == j.waddr)))
            h = 1'b1;
        if ((j.op.fpunit & i.op.fpunit) | (j.op.division & i.op.division) |
            (j.op.mult & i.op.mult) | (j.op.bitc & i.op.bitc) |
            (j.op.csreg & i.op.csreg))
            h = 1'b1;
        if ((j.op.store | j.op.fstore) & (i.op.load | i.op.fload))
            h = 1'b1;
        if (j.op.fpuf && i.op.csreg &&
            (i.caddr == csr_fflags || i.caddr == csr_fcsr))
            h = 1'b1;
        return h;
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Decode/backend facing bundle of the issue queue.
// master = decode/backend side, slave = the queue.
interface issue_queue_if;
    import issue_queue_wires::*;

    instruction_type [FETCH_WIDTH-1:0] enq_instr;
    logic                              clear;
    logic                              stall_in;
    calculation_type [ISSUE_WIDTH-1:0] issue_calc;
    logic [ICNT_W-1:0]                 issue_count;
    logic                              stall_out;
    logic [CNT_W-1:0]                  count;

    modport master (
        output enq_instr, clear, stall_in,
        input  issue_calc, issue_count, stall_out, count
    );

    modport slave (
        input  enq_instr, clear, stall_in,
        output issue_calc, issue_count, stall_out, count
    );

endinterface

// File: rtl/issue_queue_ctrl.sv
// Pointer/occupancy control, enqueue compaction, same-cycle bypass and
// in-order hazard cut of the issue window.
module issue_queue_ctrl
    import issue_queue_wires::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  issue_queue_in_type      ctrl_i,
    input  issue_queue_ram_out_type ram_i,
    output issue_queue_ram_in_type  ram_o,
    output issue_queue_out_type     ctrl_o
);

    issue_queue_reg_type r_q;
    issue_queue_reg_type r_d;
    issue_queue_reg_type v;

    instruction_type [FETCH_WIDTH-1:0] byp;
    instruction_type [ISSUE_WIDTH-1:0] win;

    logic             any_valid;
    logic             accept;
    logic             cut;
    logic             haz;
    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] ceff;
    int               nv;
    int               wsize;
    int               n;

    always_comb begin
        v         = r_q;
        ram_o     = '0;
        ctrl_o    = '0;
        byp       = '0;
        win       = '0;
        cut       = 1'b0;
        haz       = 1'b0;
        nv        = 0;
        any_valid = 1'b0;

        for (int f = 0; f < FETCH_WIDTH; f++) begin
            any_valid = any_valid | ctrl_i.enq_instr[f].op.valid;
        end
        accept = ~ctrl_i.clear & ~r_q.stall & any_valid;

        // Lane f lands at wptr + (number of valid lanes before f)
        for (int f = 0; f < FETCH_WIDTH; f++) begin
            if (accept && ctrl_i.enq_instr[f].op.valid) begin
                for (int m = 0; m < FETCH_WIDTH; m++) begin
                    if (m == nv) begin
                        ram_o.wren[m]  = 1'b1;
                        ram_o.waddr[m] = r_q.wptr + PTR_W'(m);
                        ram_o.wdata[m] = ctrl_i.enq_instr[f];
                        byp[m]         = ctrl_i.enq_instr[f];
                    end
                end
                nv = nv + 1;
            end
        end
        k    = CNT_W'(nv);
        ceff = r_q.count + k;

        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            ram_o.raddr[i] = r_q.rptr + PTR_W'(i);
            if (i < int'(r_q.count)) begin
                win[i] = ram_i.rdata[i];
            end else begin
                for (int m = 0; m < FETCH_WIDTH; m++) begin
                    if (i - int'(r_q.count) == m) win[i] = byp[m];
                end
            end
        end
        wsize = (int'(ceff) < ISSUE_WIDTH) ? int'(ceff) : ISSUE_WIDTH;

        n = wsize;
        for (int i = 1; i < ISSUE_WIDTH; i++) begin
            haz = is_serial(win[i]);
            for (int j = 0; j < i; j++) begin
                haz = haz | is_hazard(win[j], win[i]);
            end
            if (!cut && i < wsize && haz) begin
                n   = i;
                cut = 1'b1;
            end
        end
        if (is_serial(win[0]) && n > 1) n = 1;
        if (ctrl_i.clear || ctrl_i.stall_in) n = 0;

        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (i < n) ctrl_o.issue_calc[i] = to_calc(win[i]);
            else       ctrl_o.issue_calc[i] = init_calculation;
        end
        ctrl_o.issue_count = ICNT_W'(n);
        ctrl_o.stall_out   = r_q.stall;
        ctrl_o.count       = r_q.count;

        v.wptr  = r_q.wptr + PTR_W'(nv);
        v.rptr  = r_q.rptr + PTR_W'(n);
        v.count = ceff - CNT_W'(n);
        if (ctrl_i.clear) begin
            v.wptr  = '0;
            v.rptr  = '0;
            v.count = '0;
        end
        // Keep FETCH_WIDTH slots free so an accepted group never overflows
        v.stall = v.count > CNT_W'(DEPTH - FETCH_WIDTH);
        r_d     = v;
    end

    always_ff @(posedge clock) begin
        if (!reset) r_q <= init_reg;
        else        r_q <= r_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_count_bound: assert (r_q.count <= CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/issue_queue_ram.sv
// Instruction storage: DEPTH flops, FETCH_WIDTH write ports, ISSUE_WIDTH
// asynchronous read ports. Contents are deliberately not reset.
module issue_queue_ram
    import issue_queue_wires::*;
(
    input  logic                    clock,
    input  issue_queue_ram_in_type  ram_i,
    output issue_queue_ram_out_type ram_o
);

    instruction_type mem_q [DEPTH];

    // Compaction guarantees distinct addresses across enabled ports
    always_ff @(posedge clock) begin
        for (int f = 0; f < FETCH_WIDTH; f++) begin
            if (ram_i.wren[f]) begin
                mem_q[ram_i.waddr[f]] <= ram_i.wdata[f];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            ram_o.rdata[i] = mem_q[ram_i.raddr[i]];
        end
    end

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue between decode and register read: compacting
// enqueue, bypassed multi-issue with hazard screening, registered stall.
module issue_queue
    import issue_queue_wires::*;
(
    input  logic         clock,
    input  logic         reset,
    issue_queue_if.slave iq
);

    issue_queue_in_type      ctrl_in;
    issue_queue_out_type     ctrl_out;
    issue_queue_ram_in_type  ram_in;
    issue_queue_ram_out_type ram_out;

    assign ctrl_in.clear     = iq.clear;
    assign ctrl_in.stall_in  = iq.stall_in;
    assign ctrl_in.enq_instr = iq.enq_instr;

    issue_queue_ram u_ram (
        .clock (clock),
        .ram_i (ram_in),
        .ram_o (ram_out)
    );

    issue_queue_ctrl u_ctrl (
        .clock  (clock),
        .reset  (reset),
        .ctrl_i (ctrl_in),
        .ram_i  (ram_out),
        .ram_o  (ram_in),
        .ctrl_o (ctrl_out)
    );

    assign iq.issue_calc  = ctrl_out.issue_calc;
    assign iq.issue_count = ctrl_out.issue_count;
    assign iq.stall_out   = ctrl_out.stall_out;
    assign iq.count       = ctrl_out.count;

endmodule
